// File: rtl/lane_event_encoder_pkg.sv
// Shared event encoding and lane defaults.
// Used by the encoder and the judgement logic.
package lane_event_encoder_pkg;

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_RELEASE = 2'd1;
  localparam logic [1:0] EV_LONG    = 2'd2;

  localparam int LANES_DEF      = 4;
  localparam int TS_W_DEF       = 16;
  localparam int LONG_HOLD_DEF  = 500;
  localparam int FIFO_DEPTH_DEF = 4;

endpackage

// File: rtl/lane_event_encoder_fifo.sv
// First-word-fall-through event FIFO.
// Head entry is always visible on dout.
module event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr - rd_ptr) == (AW+1)'(DEPTH);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rd_ptr[AW-1:0]];

  // Pointer update; a push into a full FIFO is legal alongside a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is data-only; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/lane_event_encoder.sv
// Turns debounced lane levels into timestamped
// PRESS / RELEASE / LONG events queued in a FIFO.
module lane_event_encoder
  import lane_event_encoder_pkg::*;
#(
  parameter int LANES      = LANES_DEF,
  parameter int TS_W       = TS_W_DEF,
  parameter int LONG_HOLD  = LONG_HOLD_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic [LANES-1:0]         pbreg,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [$clog2(LANES)-1:0] ev_lane,
  output logic [1:0]               ev_type,
  output logic [TS_W-1:0]          ev_time,
  output logic [LANES-1:0]         held,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int LW = $clog2(LANES);
  localparam int CW = $clog2(LONG_HOLD + 1);
  localparam int EW = LW + 2 + TS_W;

  logic                       init;
  logic [TS_W-1:0]            ts;
  logic [TS_W-1:0]            ts_nxt;
  logic [LANES-1:0]           pend_press;
  logic [LANES-1:0]           pend_rel;
  logic [LANES-1:0]           pend_long;
  logic [LANES-1:0][TS_W-1:0] press_ts;
  logic [LANES-1:0][TS_W-1:0] rel_ts;
  logic [LANES-1:0][TS_W-1:0] long_ts;
  logic [LANES-1:0][CW-1:0]   cnt;

  logic [LANES-1:0] rise;
  logic [LANES-1:0] fall;
  logic [LANES-1:0] long_hit;
  logic [LANES-1:0] clr_press;
  logic [LANES-1:0] clr_rel;
  logic [LANES-1:0] clr_long;
  logic [LANES-1:0] busy_p;
  logic [LANES-1:0] busy_r;
  logic [LANES-1:0] busy_l;
  logic             drop;

  logic             any;
  logic [LW-1:0]    sel_lane;
  logic [1:0]       sel_type;
  logic [TS_W-1:0]  sel_ts;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [EW-1:0]    head;

  assign ts_nxt = ts + 1'b1;

  // Edge, long-hold and collision detection for every lane.
  always_comb begin
    rise     = '0;
    fall     = '0;
    long_hit = '0;
    if (!init) begin
      rise = pbreg & ~held;
      fall = ~pbreg & held;
    end
    for (int i = 0; i < LANES; i++) begin
      long_hit[i] = tick & held[i] & pbreg[i] &
                    (cnt[i] == CW'(LONG_HOLD - 1));
    end
    busy_p = pend_press & ~clr_press;
    busy_r = pend_rel & ~clr_rel;
    busy_l = pend_long & ~clr_long;
    drop = |(rise & busy_p) | |(fall & busy_r) |
           |(long_hit & busy_l);
  end

  // Pick lowest pending lane; PRESS, then LONG, then RELEASE.
  always_comb begin
    any       = 1'b0;
    sel_lane  = '0;
    sel_type  = EV_PRESS;
    sel_ts    = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (pend_press[i] | pend_long[i] | pend_rel[i]) begin
        any      = 1'b1;
        sel_lane = LW'(i);
        if (pend_press[i]) begin
          sel_type = EV_PRESS;
          sel_ts   = press_ts[i];
        end else if (pend_long[i]) begin
          sel_type = EV_LONG;
          sel_ts   = long_ts[i];
        end else begin
          sel_type = EV_RELEASE;
          sel_ts   = rel_ts[i];
        end
      end
    end
    pop  = ~empty & ev_ready;
    push = any & (~full | pop);
    clr_press = '0;
    clr_rel   = '0;
    clr_long  = '0;
    if (push) begin
      if (sel_type == EV_PRESS) clr_press[sel_lane] = 1'b1;
      if (sel_type == EV_LONG) clr_long[sel_lane] = 1'b1;
      if (sel_type == EV_RELEASE) clr_rel[sel_lane] = 1'b1;
    end
  end

  // Per-lane pending flags, timestamps and hold counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held       <= '0;
      pend_press <= '0;
      pend_rel   <= '0;
      pend_long  <= '0;
      press_ts   <= '0;
      rel_ts     <= '0;
      long_ts    <= '0;
      cnt        <= '0;
    end else begin
      held       <= pbreg;
      pend_press <= busy_p | rise;
      pend_rel   <= busy_r | fall;
      pend_long  <= busy_l | long_hit;
      for (int i = 0; i < LANES; i++) begin
        if (rise[i] & ~busy_p[i]) press_ts[i] <= ts;
        if (fall[i] & ~busy_r[i]) rel_ts[i] <= ts;
        if (long_hit[i] & ~busy_l[i]) long_ts[i] <= ts_nxt;
        if (rise[i] | fall[i])
          cnt[i] <= '0;
        else if (tick & held[i] & (cnt[i] != CW'(LONG_HOLD)))
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // Timebase, init cycle and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init     <= 1'b1;
      ts       <= '0;
      overflow <= 1'b0;
    end else begin
      init <= 1'b0;
      if (tick) ts <= ts_nxt;
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  event_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  ({sel_lane, sel_type, sel_ts}),
    .full (full),
    .pop  (pop),
    .dout (head),
    .empty(empty)
  );

  assign ev_valid = ~empty;
  assign {ev_lane, ev_type, ev_time} = ev_valid ? head : '0;

endmodule
